// File: rtl/step_pkg.sv
// step_pkg: shared FSM states and step word bit positions for step_pulse_gen
package step_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;
  localparam int STEP_DIR_BIT = 1;
  localparam int STEP_EN_BIT = 0;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/step_interval_timer.sv
// step_interval_timer: loadable down-counter giving the step/settle tick
// Ports: clk/rst (async active-high), i_start loads first interval, i_step loads
// next interval, i_settle loads SETTLE_CYC-1 (wins over the others), i_period is
// the clamped step period, o_tick is high while the counter sits at zero.
// STEP_RAMP_EN adds an interval register that ramps from RAMP_START down to i_period.
module step_interval_timer
  import step_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int SETTLE_CYC = 4
`ifdef STEP_RAMP_EN
  ,
  parameter int RAMP_START = 64,
  parameter int RAMP_DEC = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_settle,
  input  logic [PER_W-1:0] i_period,
  output logic             o_tick
);
  logic [PER_W-1:0] r_cnt, w_first, w_next;
`ifdef STEP_RAMP_EN
  logic [PER_W-1:0] r_ivl;
  logic [PER_W:0]   w_floor;
  assign w_first = (PER_W'(RAMP_START) > i_period) ? PER_W'(RAMP_START) : i_period;
  // widened so the subtraction can never wrap below the floor
  assign w_floor = {1'b0, i_period} + (PER_W+1)'(RAMP_DEC);
  assign w_next = ({1'b0, r_ivl} >= w_floor) ? r_ivl - PER_W'(RAMP_DEC) : i_period;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ivl <= '0;
    else if (i_start) r_ivl <= w_first;
    else if (i_step) r_ivl <= w_next;
`else
  assign w_first = i_period;
  assign w_next = i_period;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_settle) r_cnt <= PER_W'(SETTLE_CYC - 1);
    else if (i_start) r_cnt <= w_first - PER_W'(1);
    else if (i_step) r_cnt <= w_next - PER_W'(1);
    else if (r_cnt != '0) r_cnt <= r_cnt - PER_W'(1);
  assign o_tick = r_cnt == '0;
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: absolute-target step command generator for the half-step coil driver
// Ports: system1000 clock, system1000_rst async active-high reset; cmd_valid/cmd_ready
// handshake with cmd_target (signed) and cmd_period; abort stops a move;
// step_cmd = {dir, en}; position is the signed current position; busy in MOVE/SETTLE;
// done pulses once per completed command. Optional macro: STEP_RAMP_EN.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int PER_W = 16,
  parameter int SETTLE_CYC = 4
`ifdef STEP_RAMP_EN
  ,
  parameter int RAMP_START = 64,
  parameter int RAMP_DEC = 4
`endif
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [POS_W-1:0] cmd_target,
  input  logic        [PER_W-1:0] cmd_period,
  input  logic                    abort,
  output logic        [1:0]       step_cmd,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done
);
  state_t r_state, w_state;
  logic signed [POS_W-1:0] r_target, r_pos, w_pos;
  logic [PER_W-1:0] r_per, w_per;
  logic r_dir, r_en, r_busy, r_done;
  logic w_dir, w_en, w_done, w_start, w_step, w_settle, w_tick;
  // period follows the input while idle so the accept edge captures it
  assign w_per = (r_state != IDLE) ? r_per :
                 (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
  step_interval_timer #(
    .PER_W(PER_W),
    .SETTLE_CYC(SETTLE_CYC)
`ifdef STEP_RAMP_EN
    ,
    .RAMP_START(RAMP_START),
    .RAMP_DEC(RAMP_DEC)
`endif
  ) u_timer (
    .clk(system1000),
    .rst(system1000_rst),
    .i_start(w_start),
    .i_step(w_step),
    .i_settle(w_settle),
    .i_period(w_per),
    .o_tick(w_tick)
  );
  always_comb begin
    w_state = r_state;
    w_pos = r_pos;
    w_dir = r_dir;
    w_en = 1'b0;
    w_done = 1'b0;
    w_start = 1'b0;
    w_step = 1'b0;
    w_settle = 1'b0;
    case (r_state)
      IDLE:
        if (cmd_valid) begin
          if (cmd_target == r_pos) w_done = 1'b1;
          else begin
            w_dir = cmd_target > r_pos;
            w_state = MOVE;
            w_start = 1'b1;
          end
        end
      MOVE:
        if (abort) begin
          w_state = SETTLE;
          w_settle = 1'b1;
        end else if (w_tick) begin
          w_en = 1'b1;
          w_step = 1'b1;
          w_pos = r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
          if (w_pos == r_target) begin
            w_state = SETTLE;
            w_settle = 1'b1;
          end
        end
      SETTLE:
        if (w_tick) begin
          w_done = 1'b1;
          w_state = IDLE;
        end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge system1000 or posedge system1000_rst)
    if (system1000_rst) begin
      r_state <= IDLE;
      r_pos <= '0;
      r_target <= '0;
      r_per <= '0;
      r_dir <= 1'b0;
      r_en <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pos <= w_pos;
      r_per <= w_per;
      r_dir <= w_dir;
      r_en <= w_en;
      r_done <= w_done;
      r_busy <= w_state != IDLE;
      if (w_start) r_target <= cmd_target;
    end
  always_comb begin
    step_cmd = '0;
    step_cmd[STEP_DIR_BIT] = r_dir;
    step_cmd[STEP_EN_BIT] = r_en;
  end
  assign cmd_ready = r_state == IDLE;
  assign position = r_pos;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: table, random and reset-corner checks of step_pulse_gen against a timeline model
module tb_step_pulse_gen;
  localparam int SC = 4;
`ifdef STEP_RAMP_EN
  localparam int RS = 20;
  localparam int RD = 4;
`endif
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, abort, busy, done;
  logic signed [15:0] cmd_target, position;
  logic [15:0] cmd_period;
  logic [1:0] step_cmd;
  int total = 0;
  int bad = 0;
  int mpos, mdir;
  typedef struct {
    int target;
    int period;
    int abort_k;
    bit noise;
    int exp_pos;
    int exp_en;
  } vec_t;
  vec_t vt[8];
  always #5 clk = ~clk;
  step_pulse_gen #(
    .POS_W(16),
    .PER_W(16),
    .SETTLE_CYC(SC)
`ifdef STEP_RAMP_EN
    ,
    .RAMP_START(RS),
    .RAMP_DEC(RD)
`endif
  ) dut (
    .system1000(clk),
    .system1000_rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_target(cmd_target),
    .cmd_period(cmd_period),
    .abort(abort),
    .step_cmd(step_cmd),
    .position(position),
    .busy(busy),
    .done(done)
  );
  function automatic int iv_first(input int p);
`ifdef STEP_RAMP_EN
    return RS > p ? RS : p;
`else
    return p;
`endif
  endfunction
  function automatic int iv_next(input int iv, input int p);
`ifdef STEP_RAMP_EN
    return (iv - RD) > p ? iv - RD : p;
`else
    return (iv > 0) ? p : p;
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  // Model: from the command, compute the absolute edge of every en pulse, the
  // abort edge and the done edge, then compare the DUT every cycle.
  task automatic run_cmd(input int tgt, input int per, input int k, input bit noise,
                         input string nm, output int en_cnt);
    int p, n, nst, acc, iv, a, last, d, steps;
    bit dirb, en, bsy;
    int t[$];
    logic [20:0] ex, ac;
    p = per < 2 ? 2 : per;
    n = tgt > mpos ? tgt - mpos : mpos - tgt;
    dirb = (n == 0) ? mdir[0] : (tgt > mpos);
    nst = (k >= 0) ? k : n;
    acc = 0;
    iv = iv_first(p);
    for (int i = 0; i < nst; i++) begin
      acc += iv;
      t.push_back(acc);
      iv = iv_next(iv, p);
    end
    a = acc + iv;
    last = (n == 0) ? 0 : (k >= 0 ? a : acc);
    d = (n == 0) ? 0 : last + SC;
    en_cnt = 0;
    steps = 0;
    cmd_target = 16'(tgt);
    cmd_period = 16'(per);
    cmd_valid = 1'b1;
    abort = 1'b0;
    for (int c = 0; c <= d + 2; c++) begin
      if (c > 0) begin
        cmd_valid = noise && n != 0 && c < d;
        if (cmd_valid) begin
          cmd_target = 16'($urandom_range(200));
          cmd_period = 16'($urandom_range(9));
        end
        abort = (k >= 0 && c >= a) || (noise && n != 0 && c > last);
      end
      tick;
      steps = 0;
      en = 1'b0;
      foreach (t[i]) begin
        if (t[i] <= c) steps++;
        if (t[i] == c) en = 1'b1;
      end
      bsy = n != 0 && c < d;
      ex = {en, dirb, 16'(dirb ? mpos + steps : mpos - steps), bsy, c == d, !bsy};
      ac = {step_cmd[0], step_cmd[1], position, busy, done, cmd_ready};
      en_cnt += int'(step_cmd[0]);
      chk($sformatf("%s c%0d", nm, c), 64'(ac), 64'(ex));
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    mpos = dirb ? mpos + steps : mpos - steps;
    mdir = int'(dirb);
  endtask
  initial begin
    int ec, tg, pr, k, n, t1;
    rst = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_target = '0;
    cmd_period = '0;
    mpos = 0;
    mdir = 0;
    #3;
    chk("reset", 64'({step_cmd, position, busy, done, cmd_ready}), 64'({2'b00, 16'h0000, 3'b001}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vt[0] = '{3, 4, -1, 1'b0, 3, 3};
    vt[1] = '{3, 7, -1, 1'b1, 3, 0};
    vt[2] = '{0, 0, -1, 1'b1, 0, 3};
    vt[3] = '{-2, 2, -1, 1'b0, -2, 2};
    vt[4] = '{0, 1, -1, 1'b1, 0, 2};
    vt[5] = '{5, 3, 2, 1'b1, 2, 2};
    vt[6] = '{2, 5, -1, 1'b0, 2, 0};
    vt[7] = '{7, 8, -1, 1'b0, 7, 5};
    for (int i = 0; i < 8; i++) begin
      run_cmd(vt[i].target, vt[i].period, vt[i].abort_k, vt[i].noise, $sformatf("vec%0d", i), ec);
      chk($sformatf("vec%0d pos", i), 64'(position), 64'(16'(vt[i].exp_pos)));
      chk($sformatf("vec%0d en_count", i), 64'(ec), 64'(vt[i].exp_en));
    end
    for (int r = 0; r < 24; r++) begin
      tg = mpos + int'($urandom_range(12)) - 6;
      pr = int'($urandom_range(5));
      n = tg > mpos ? tg - mpos : mpos - tg;
      k = (n > 0 && $urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
      run_cmd(tg, pr, k, 1'($urandom_range(1)), $sformatf("rnd%0d", r), ec);
    end
    t1 = iv_first(3);
    cmd_target = 16'(mpos + 10);
    cmd_period = 16'd3;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int c = 1; c <= t1; c++) tick;
    chk("rst_pre_en", 64'(step_cmd), 64'({1'b1, 1'b1}));
    rst = 1'b1;
    #1;
    chk("rst_async", 64'({step_cmd, position, busy, done, cmd_ready}), 64'({2'b00, 16'h0000, 3'b001}));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk($sformatf("rst_after c%0d", c), 64'({step_cmd[0], position, busy, done, cmd_ready}),
          64'({1'b0, 16'h0000, 3'b001}));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
